param_stack_datapath: RTL and testbench
=======================================

Name: param_stack_datapath

Overview:
Parametrised successor to the fixed 16-bit push/pop stack-plus-ALU datapath. Holds a DEPTH-entry LIFO of WIDTH-bit signed words, with the top two entries feeding an ALU. Adds occupancy tracking, full/empty flags, a sticky stack-error flag and a ROT operation. Sits between the instruction decoder (stackOP/aluOP/mux_selector) and the branch and program-counter logic (ALU_out).

Parameters:
WIDTH, 16, data word width in bits (>=4).
DEPTH, 16, number of stack entries (>=3).

Ports:
CLK  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
stackOP  input  3  stack operation code (see Behaviour).
aluOP  input  4  ALU function select.
mux_selector  input  1  PUSH source: 1 = immediate, 0 = ALU_out.
immediate  input  WIDTH  immediate operand for PUSH.
aOut  output  WIDTH  top of stack; 0 if count < 1.
bOut  output  WIDTH  second of stack; 0 if count < 2.
ALU_out  output  WIDTH  combinational ALU result from aOut/bOut.
Overflow  output  1  combinational signed overflow for add/sub; 0 for all other aluOP.
full  output  1  count == DEPTH.
empty  output  1  count == 0.
depth_count  output  $clog2(DEPTH+1)  current occupancy.
stack_err  output  1  sticky error flag.

Behaviour:
- Reset (reset low, asynchronous): all entries = 0; count = 0; stack_err = 0. Resulting outputs: aOut = 0, bOut = 0, empty = 1, full = 0.
- ALU, combinational. A = aOut (top), B = bOut (second).
  - 0 add: B+A. 1 sub: B-A. 2 and. 3 or. 4 xor.
  - 5 passA (dup). 6 passB (over).
  - 7 eq: 1 if A==B. 8 eqz: 1 if A==0. 9 slt: 1 if B<A, signed.
  - 10-15: result 0.
  - Results are truncated to WIDTH bits.
- stackOP, applied at the rising edge:
  - 0 NOP: no change.
  - 1 PUSH: value = mux_selector ? immediate : ALU_out; push it, count+1.
    - If full: stack unchanged, stack_err set.
  - 2 BINOP: pop two, push ALU_out.
    - Normal case (count >= 2): new count = count-1.
    - If count < 2: missing operands read 0, result is written to top, new count = 1, stack_err set.
  - 3 DROP: pop, count-1.
    - If empty: no change, stack_err set.
  - 4 CMP: no stack change. ALU_out is valid combinationally for branch logic within the same cycle.
  - 5 SWAP: exchange top and second.
    - If count < 2: no change, stack_err set.
  - 6 ROT: (x1 x2 x3 -- x2 x3 x1); third entry to top, top to second, second to third.
    - If count < 3: no change, stack_err set.
  - 7 CLEAR: synchronous; count = 0, all entries = 0, stack_err = 0.
- Freed entries are written 0, so a popped value never reappears in aOut or bOut.
- stack_err is sticky; only reset or CLEAR clear it.
- Latency: 1 cycle from an op to updated aOut/bOut/count. Flags are derived from count.
- Reset asserted mid-operation overrides any in-flight op.

Optional Feature:
STACK_PEEK_EN.
- Defined: adds input peek_idx (width $clog2(DEPTH)) and output peek_data (WIDTH).
  - peek_data is the combinational value of entry peek_idx, where 0 = top.
  - Reads 0 when peek_idx >= count.
- Undefined: neither port exists; behaviour is otherwise identical.

Test Plan:
- Reset; PUSH 1; PUSH 2; BINOP sub -> aOut=-1, bOut=0, depth_count=1, stack_err=0.
- Reset; PUSH 0x7FFF (WIDTH=16); PUSH 1; aluOP add in CMP -> ALU_out=0x8000, Overflow=1, no stack change.
- Reset; PUSH 3; PUSH 7; PUSH 9; ROT -> aOut=3, bOut=9, depth_count=3. Then SWAP -> aOut=9, bOut=3.
- Reset; PUSH DEPTH times (values 1..DEPTH) -> full=1, aOut=DEPTH. One more PUSH 99 -> aOut unchanged, stack_err=1, depth_count=DEPTH.
- Reset; DROP on empty -> stack_err=1, aOut=0, empty=1. Then CLEAR -> stack_err=0. Then PUSH 5; aluOP dup with PUSH -> aOut=5, bOut=5.
- Reset; PUSH 4; assert reset mid-cycle during a PUSH 6 -> aOut=0 and empty=1 immediately; no push after release.

Source files
------------

// File: rtl/param_stack_datapath.sv
// Parametrised LIFO stack (entry 0 = top) whose top two entries feed a signed ALU.
// Optional build macro STACK_PEEK_EN adds a combinational peek port into the stack.
module param_stack_datapath #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic [2:0]                 stackOP,
  input  logic [3:0]                 aluOP,
  input  logic                       mux_selector,
  input  logic [WIDTH-1:0]           immediate,
  output logic [WIDTH-1:0]           aOut,
  output logic [WIDTH-1:0]           bOut,
  output logic [WIDTH-1:0]           ALU_out,
  output logic                       Overflow,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] depth_count,
`ifdef STACK_PEEK_EN
  input  logic [$clog2(DEPTH)-1:0]   peek_idx,
  output logic [WIDTH-1:0]           peek_data,
`endif
  output logic                       stack_err
);

  localparam int CW = $clog2(DEPTH+1);

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_PUSH  = 3'd1;
  localparam logic [2:0] OP_BINOP = 3'd2;
  localparam logic [2:0] OP_DROP  = 3'd3;
  localparam logic [2:0] OP_CMP   = 3'd4;
  localparam logic [2:0] OP_SWAP  = 3'd5;
  localparam logic [2:0] OP_ROT   = 3'd6;
  localparam logic [2:0] OP_CLEAR = 3'd7;

  logic [WIDTH-1:0] entry      [DEPTH];
  logic [WIDTH-1:0] entry_next [DEPTH];
  logic [CW-1:0]    count, count_next;
  logic             err, err_next;
  logic [WIDTH-1:0] push_val;

  assign aOut        = (count >= CW'(1)) ? entry[0] : '0;
  assign bOut        = (count >= CW'(2)) ? entry[1] : '0;
  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign depth_count = count;
  assign stack_err   = err;
  assign push_val    = mux_selector ? immediate : ALU_out;

  // ALU: A is the top of stack, B the entry beneath it.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    ALU_out  = '0;
    Overflow = 1'b0;
    case (aluOP)
      4'd0: begin
        ALU_out  = bOut + aOut;
        Overflow = (aOut[WIDTH-1] == bOut[WIDTH-1]) && (ALU_out[WIDTH-1] != bOut[WIDTH-1]);
      end
      4'd1: begin
        ALU_out  = bOut - aOut;
        Overflow = (aOut[WIDTH-1] != bOut[WIDTH-1]) && (ALU_out[WIDTH-1] != bOut[WIDTH-1]);
      end
      4'd2:    ALU_out = bOut & aOut;
      4'd3:    ALU_out = bOut | aOut;
      4'd4:    ALU_out = bOut ^ aOut;
      4'd5:    ALU_out = aOut;
      4'd6:    ALU_out = bOut;
      4'd7:    ALU_out = WIDTH'(aOut == bOut);
      4'd8:    ALU_out = WIDTH'(aOut == '0);
      4'd9:    ALU_out = WIDTH'($signed(bOut) < $signed(aOut));
      default: ALU_out = '0;
    endcase
  end

  // Next-state: pushes shift entries down, pops shift them up and zero the bottom
  // slot, so a popped value can never resurface.
  always_comb begin
    entry_next = entry;
    count_next = count;
    err_next   = err;
    case (stackOP)
      OP_PUSH: begin
        if (full) begin
          err_next = 1'b1;
        end else begin
          for (int i = DEPTH-1; i > 0; i--) entry_next[i] = entry[i-1];
          entry_next[0] = push_val;
          count_next    = count + CW'(1);
        end
      end
      OP_BINOP: begin
        if (count >= CW'(2)) begin
          entry_next[0] = ALU_out;
          for (int i = 1; i < DEPTH-1; i++) entry_next[i] = entry[i+1];
          entry_next[DEPTH-1] = '0;
          count_next = count - CW'(1);
        end else begin
          entry_next[0] = ALU_out;
          count_next    = CW'(1);
          err_next      = 1'b1;
        end
      end
      OP_DROP: begin
        if (empty) begin
          err_next = 1'b1;
        end else begin
          for (int i = 0; i < DEPTH-1; i++) entry_next[i] = entry[i+1];
          entry_next[DEPTH-1] = '0;
          count_next = count - CW'(1);
        end
      end
      OP_SWAP: begin
        if (count < CW'(2)) begin
          err_next = 1'b1;
        end else begin
          entry_next[0] = entry[1];
          entry_next[1] = entry[0];
        end
      end
      OP_ROT: begin
        if (count < CW'(3)) begin
          err_next = 1'b1;
        end else begin
          entry_next[0] = entry[2];
          entry_next[1] = entry[0];
          entry_next[2] = entry[1];
        end
      end
      OP_CLEAR: begin
        for (int i = 0; i < DEPTH; i++) entry_next[i] = '0;
        count_next = '0;
        err_next   = 1'b0;
      end
      OP_NOP, OP_CMP: ;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      // NOTE: the storage array is reset too, because stale entries would be visible after pushes/peeks.
      for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all registers update together.
      entry <= entry_next;
      count <= count_next;
      err   <= err_next;
    end
  end

`ifdef STACK_PEEK_EN
  assign peek_data = (CW'(peek_idx) < count) ? entry[peek_idx] : '0;
`endif

endmodule

// File: tb/tb_param_stack_datapath.sv
// Directed self-checking bench for param_stack_datapath (default WIDTH=16, DEPTH=16).
module tb_param_stack_datapath;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH+1);

  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, BINOP = 3'd2, DROP = 3'd3,
                         CMP = 3'd4, SWAP = 3'd5, ROT  = 3'd6, CLEAR = 3'd7;

  logic             CLK = 1'b0;
  logic             reset = 1'b0;
  logic [2:0]       stackOP = NOP;
  logic [3:0]       aluOP = 4'd0;
  logic             mux_selector = 1'b1;
  logic [WIDTH-1:0] immediate = '0;
  logic [WIDTH-1:0] aOut, bOut, ALU_out;
  logic             Overflow, full, empty, stack_err;
  logic [CW-1:0]    depth_count;

  int total_cnt = 0;
  int pass_cnt  = 0;

  param_stack_datapath #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .reset(reset), .stackOP(stackOP), .aluOP(aluOP),
    .mux_selector(mux_selector), .immediate(immediate),
    .aOut(aOut), .bOut(bOut), .ALU_out(ALU_out), .Overflow(Overflow),
    .full(full), .empty(empty), .depth_count(depth_count), .stack_err(stack_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else pass_cnt++;
  endtask

  // Apply one op across a rising edge, then return #1 after the edge with stackOP back at NOP.
  task automatic op(input logic [2:0] s, input logic [3:0] a, input logic sel, input logic [WIDTH-1:0] imm);
    @(negedge CLK);
    stackOP = s; aluOP = a; mux_selector = sel; immediate = imm;
    @(posedge CLK);
    #1 stackOP = NOP;
  endtask

  task automatic push_imm(input logic [WIDTH-1:0] v);
    op(PUSH, 4'd0, 1'b1, v);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    reset = 1'b0; stackOP = NOP;
    @(negedge CLK);
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    do_reset();
    check("rst_aOut", aOut, 0);
    check("rst_bOut", bOut, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", depth_count, 0);
    check("rst_err", stack_err, 0);

    // PUSH 1; PUSH 2; BINOP sub -> 1-2 = -1
    push_imm(16'd1);
    push_imm(16'd2);
    check("push2_aOut", aOut, 2);
    check("push2_bOut", bOut, 1);
    op(BINOP, 4'd1, 1'b1, '0);
    check("sub_aOut", aOut, 16'hFFFF);
    check("sub_bOut", bOut, 0);
    check("sub_count", depth_count, 1);
    check("sub_err", stack_err, 0);

    // Signed overflow on add via CMP; ALU checked combinationally before the edge
    do_reset();
    push_imm(16'h7FFF);
    push_imm(16'h0001);
    @(negedge CLK);
    stackOP = CMP; aluOP = 4'd0;
    #1;
    check("cmp_add_alu", ALU_out, 16'h8000);
    check("cmp_add_ovf", Overflow, 1);
    aluOP = 4'd1; #1;
    check("sub_alu", ALU_out, 16'h7FFE);
    check("sub_ovf", Overflow, 0);
    aluOP = 4'd9; #1;
    check("slt_alu", ALU_out, 0);
    aluOP = 4'd2; #1;
    check("and_ovf", Overflow, 0);
    check("and_alu", ALU_out, 16'h0001);
    aluOP = 4'd12; #1;
    check("op12_alu", ALU_out, 0);
    aluOP = 4'd0;
    @(posedge CLK); #1 stackOP = NOP;
    check("cmp_aOut", aOut, 16'h0001);
    check("cmp_bOut", bOut, 16'h7FFF);
    check("cmp_count", depth_count, 2);

    // ROT then SWAP
    do_reset();
    push_imm(16'd3);
    push_imm(16'd7);
    push_imm(16'd9);
    op(ROT, 4'd0, 1'b1, '0);
    check("rot_aOut", aOut, 3);
    check("rot_bOut", bOut, 9);
    check("rot_count", depth_count, 3);
    check("rot_err", stack_err, 0);
    op(SWAP, 4'd0, 1'b1, '0);
    check("swap_aOut", aOut, 9);
    check("swap_bOut", bOut, 3);
    // Third entry after ROT is 7: drop twice to expose it
    op(DROP, 4'd0, 1'b1, '0);
    op(DROP, 4'd0, 1'b1, '0);
    check("rot_third", aOut, 7);
    check("rot_third_b", bOut, 0);

    // ROT with only two entries is an error and leaves the stack alone
    do_reset();
    push_imm(16'd1);
    push_imm(16'd2);
    op(ROT, 4'd0, 1'b1, '0);
    check("rot2_err", stack_err, 1);
    check("rot2_aOut", aOut, 2);
    check("rot2_bOut", bOut, 1);

    // Fill to DEPTH, then overflow push
    do_reset();
    for (int i = 1; i <= DEPTH; i++) push_imm(WIDTH'(i));
    check("fill_full", full, 1);
    check("fill_aOut", aOut, DEPTH);
    check("fill_err", stack_err, 0);
    push_imm(16'd99);
    check("ovf_aOut", aOut, DEPTH);
    check("ovf_bOut", bOut, DEPTH-1);
    check("ovf_err", stack_err, 1);
    check("ovf_count", depth_count, DEPTH);

    // DROP on empty, CLEAR, then dup through the ALU path
    do_reset();
    op(DROP, 4'd0, 1'b1, '0);
    check("drop_empty_err", stack_err, 1);
    check("drop_empty_aOut", aOut, 0);
    check("drop_empty_empty", empty, 1);
    op(CLEAR, 4'd0, 1'b1, '0);
    check("clear_err", stack_err, 0);
    push_imm(16'd5);
    op(PUSH, 4'd5, 1'b0, 16'd77);
    check("dup_aOut", aOut, 5);
    check("dup_bOut", bOut, 5);
    check("dup_count", depth_count, 2);
    op(DROP, 4'd0, 1'b1, '0);
    op(DROP, 4'd0, 1'b1, '0);
    check("drained_aOut", aOut, 0);
    check("drained_empty", empty, 1);
    check("drained_err", stack_err, 0);

    // BINOP with one operand: missing B reads 0, count becomes 1, error set
    do_reset();
    push_imm(16'd5);
    op(BINOP, 4'd0, 1'b1, '0);
    check("binop1_aOut", aOut, 5);
    check("binop1_count", depth_count, 1);
    check("binop1_err", stack_err, 1);
    op(CLEAR, 4'd0, 1'b1, '0);
    check("clear_empty", empty, 1);

    // Asynchronous reset in the middle of a PUSH 6
    do_reset();
    push_imm(16'd4);
    @(negedge CLK);
    stackOP = PUSH; mux_selector = 1'b1; immediate = 16'd6;
    #2 reset = 1'b0;
    #1;
    check("async_aOut", aOut, 0);
    check("async_empty", empty, 1);
    @(posedge CLK); #1;
    stackOP = NOP;
    @(negedge CLK);
    reset = 1'b1;
    @(posedge CLK); #1;
    check("post_rel_aOut", aOut, 0);
    check("post_rel_empty", empty, 1);
    check("post_rel_count", depth_count, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
